// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifq_pkg;

  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_SEL_W     = 2;
  localparam int TAG_W          = 28;
  localparam int WORD_W         = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered cache line together with the line address it came from.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } ifq_entry_t;

  // Byte address of the instruction after word w of line tag.
  function automatic logic [31:0] ifq_pc_plus4(input logic [TAG_W-1:0] tag,
                                               input logic [WORD_SEL_W-1:0] w);
    return {tag, w, 2'b00} + 32'd4;
  endfunction

endpackage

// File: rtl/ifq_line_ram.sv
// Line storage for the fetch queue: one clocked write port, one
// combinational read port, no reset on the data array.
module ifq_line_ram
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            Clk,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  ifq_entry_t      i_wr_data,
  input  logic [AW-1:0]   i_rd_addr,
  output ifq_entry_t      o_rd_data
);

  ifq_entry_t r_mem [DEPTH];

  // Capture a fetched line with its tag.
  always_ff @(posedge Clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: buffers 128-bit I-cache lines in a circular
// buffer and hands one instruction at a time to dispatch. A redirect
// flushes everything and restarts fetch at the target address.
// Optional build macro IFQ_STALL_CNT_EN adds a saturating 16-bit counter
// of cycles in which dispatch found the queue empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               Clk,
  input  logic               Resetb,
  output logic               Cache_Rd_En,
  output logic [31:0]        Cache_Addr,
  input  logic [LINE_W-1:0]  Cache_Dout,
  input  logic               Cache_Read_Hit,
  output logic [31:0]        Ifetch_Instruction,
  output logic [31:0]        Ifetch_PC_Plus4,
  output logic               Ifetch_Empty,
`ifdef IFQ_STALL_CNT_EN
  output logic [15:0]        Ifetch_Stall_Cnt,
`endif
  input  logic               Dispatch_Ren,
  input  logic               Redirect_Valid,
  input  logic [31:0]        Redirect_Addr
);

  localparam int AW = $clog2(DEPTH);

  logic [TAG_W-1:0]      r_fpc;
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [WORD_SEL_W-1:0] r_rd_word;

  logic       w_full;
  logic       w_empty;
  logic       w_wr_en;
  logic       w_rd_fire;
  logic       w_last_word;
  ifq_entry_t w_wr_entry;
  ifq_entry_t w_head;
  logic       w_unused;

  // The low two redirect bits select a byte inside a word and carry no meaning here.
  assign w_unused = ^Redirect_Addr[1:0];

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Reset also gates the request so the cache sees nothing while held in reset.
  assign Cache_Rd_En = Resetb && !w_full && !Redirect_Valid;
  assign Cache_Addr  = {r_fpc, 4'b0000};

  assign w_wr_en     = Cache_Rd_En && Cache_Read_Hit;
  assign w_rd_fire   = Dispatch_Ren && !w_empty && !Redirect_Valid;
  assign w_last_word = (r_rd_word == WORD_SEL_W'(WORDS_PER_LINE - 1));

  assign w_wr_entry.tag  = r_fpc;
  assign w_wr_entry.data = Cache_Dout;

  ifq_line_ram #(
    .DEPTH (DEPTH)
  ) u_line_ram (
    .Clk       (Clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (w_wr_entry),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_head)
  );

  assign Ifetch_Empty       = w_empty;
  assign Ifetch_Instruction = w_empty ? 32'h0 : w_head.data[{r_rd_word, 5'b00000} +: WORD_W];
  assign Ifetch_PC_Plus4    = w_empty ? 32'h0 : ifq_pc_plus4(w_head.tag, r_rd_word);

  // Pointer, fetch PC and word offset update; a redirect overrides any fill or read.
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      r_fpc     <= RESET_PC[31:4];
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_word <= RESET_PC[3:2];
    end else if (Redirect_Valid) begin
      r_fpc     <= Redirect_Addr[31:4];
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_word <= Redirect_Addr[3:2];
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
        r_fpc    <= r_fpc + TAG_W'(1);
      end
      if (w_rd_fire) begin
        if (w_last_word) begin
          r_rd_word <= '0;
          r_rd_ptr  <= r_rd_ptr + (AW+1)'(1);
        end else begin
          r_rd_word <= r_rd_word + WORD_SEL_W'(1);
        end
      end
    end
  end

`ifdef IFQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Count cycles with nothing to dispatch, excluding redirect cycles, saturating.
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      r_stall_cnt <= '0;
    end else if (w_empty && !Redirect_Valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign Ifetch_Stall_Cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios followed by
// randomized traffic, compared against a word-level queue model.
module tb_ifetch_queue;

   localparam int DEPTH = 4;

   logic          Clk = 1'b0;
   logic          Resetb;
   logic          Cache_Rd_En;
   logic [31:0]   Cache_Addr;
   logic [127:0]  Cache_Dout;
   logic          Cache_Read_Hit;
   logic [31:0]   Ifetch_Instruction;
   logic [31:0]   Ifetch_PC_Plus4;
   logic          Ifetch_Empty;
   logic          Dispatch_Ren;
   logic          Redirect_Valid;
   logic [31:0]   Redirect_Addr;
`ifdef IFQ_STALL_CNT_EN
   logic [15:0]   Ifetch_Stall_Cnt;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
      bit          last;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] mFpc;
   logic [1:0]  mSkip;
   int          mLines;
   logic [15:0] mStall;
   bit          mFill;
   bit          mRead;

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .Clk                (Clk),
      .Resetb             (Resetb),
      .Cache_Rd_En        (Cache_Rd_En),
      .Cache_Addr         (Cache_Addr),
      .Cache_Dout         (Cache_Dout),
      .Cache_Read_Hit     (Cache_Read_Hit),
      .Ifetch_Instruction (Ifetch_Instruction),
      .Ifetch_PC_Plus4    (Ifetch_PC_Plus4),
      .Ifetch_Empty       (Ifetch_Empty),
`ifdef IFQ_STALL_CNT_EN
      .Ifetch_Stall_Cnt   (Ifetch_Stall_Cnt),
`endif
      .Dispatch_Ren       (Dispatch_Ren),
      .Redirect_Valid     (Redirect_Valid),
      .Redirect_Addr      (Redirect_Addr)
   );

   always #5 Clk = ~Clk;

   // Instruction memory contents: word at byte address a.
   function automatic logic [31:0] cacheWord(input logic [31:0] a);
      return 32'h2000_0000 + {2'b00, a[31:2]};
   endfunction

   // The cache returns the line for whatever address is requested.
   assign Cache_Dout = {cacheWord(Cache_Addr + 32'd12), cacheWord(Cache_Addr + 32'd8),
                        cacheWord(Cache_Addr + 32'd4),  cacheWord(Cache_Addr)};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic ren, input logic hit, input logic redir,
                                input logic [31:0] addr);
      @(posedge Clk);
      #1;
      Dispatch_Ren   = ren;
      Cache_Read_Hit = hit;
      Redirect_Valid = redir;
      Redirect_Addr  = addr;
   endtask

   // Reference model: a queue of instruction words, fed a line at a time.
   always @(posedge Clk or negedge Resetb) begin
      if (!Resetb) begin
         expQ.delete();
         mFpc   = 32'h0;
         mSkip  = 2'd0;
         mLines = 0;
         mStall = 16'h0;
      end else begin
         mFill = (mLines < DEPTH) && !Redirect_Valid && Cache_Read_Hit;
         mRead = Dispatch_Ren && (expQ.size() > 0) && !Redirect_Valid;
         if (expQ.size() == 0 && !Redirect_Valid && mStall != 16'hFFFF) mStall = mStall + 16'd1;
         if (Redirect_Valid) begin
            expQ.delete();
            mLines = 0;
            mFpc   = {Redirect_Addr[31:4], 4'h0};
            mSkip  = Redirect_Addr[3:2];
         end else begin
            if (mRead) begin
               if (expQ[0].last) mLines--;
               void'(expQ.pop_front());
            end
            if (mFill) begin
               for (int w = int'(mSkip); w < 4; w++) begin
                  exp_t e;
                  e.instr = cacheWord(mFpc + 32'(4 * w));
                  e.pc4   = mFpc + 32'(4 * w) + 32'd4;
                  e.last  = (w == 3);
                  expQ.push_back(e);
               end
               mLines++;
               mSkip = 2'd0;
               mFpc  = mFpc + 32'd16;
            end
         end
      end
   end

   // Monitor: compare the DUT's presented outputs with the model head.
   always @(negedge Clk) begin
      if (Resetb === 1'b1) begin
         checkOutput("rd_en", 32'(Cache_Rd_En), 32'((mLines < DEPTH) && !Redirect_Valid));
         checkOutput("cache_addr", Cache_Addr, mFpc);
         checkOutput("empty", 32'(Ifetch_Empty), 32'(expQ.size() == 0));
         if (expQ.size() == 0) begin
            checkOutput("instr_when_empty", Ifetch_Instruction, 32'h0);
         end else begin
            checkOutput("instr", Ifetch_Instruction, expQ[0].instr);
            checkOutput("pc_plus4", Ifetch_PC_Plus4, expQ[0].pc4);
         end
`ifdef IFQ_STALL_CNT_EN
         checkOutput("stall_cnt", 32'(Ifetch_Stall_Cnt), 32'(mStall));
`endif
      end
   end

   // Assert reset between edges and check that outputs respond without a clock.
   task automatic pulseReset();
      @(negedge Clk);
      #2;
      Resetb = 1'b0;
      #1;
      checkOutput("reset_rd_en", 32'(Cache_Rd_En), 32'h0);
      checkOutput("reset_empty", 32'(Ifetch_Empty), 32'h1);
      checkOutput("reset_instr", Ifetch_Instruction, 32'h0);
      checkOutput("reset_pc4", Ifetch_PC_Plus4, 32'h0);
      checkOutput("reset_addr", Cache_Addr, 32'h0);
`ifdef IFQ_STALL_CNT_EN
      checkOutput("reset_stall", 32'(Ifetch_Stall_Cnt), 32'h0);
`endif
      @(negedge Clk);
      #2;
      Resetb = 1'b1;
   endtask

   initial begin
      int renPct;
      Resetb         = 1'b1;
      Dispatch_Ren   = 1'b0;
      Cache_Read_Hit = 1'b0;
      Redirect_Valid = 1'b0;
      Redirect_Addr  = 32'h0;
      #1;
      Resetb = 1'b0;
      #1;
      checkOutput("init_rd_en", 32'(Cache_Rd_En), 32'h0);
      checkOutput("init_empty", 32'(Ifetch_Empty), 32'h1);
      @(negedge Clk);
      #2;
      Resetb = 1'b1;

      // Fill until full with no reads, then drain one line and keep going.
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

      // Redirect into a half-full queue while a hit is returned.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_1238);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      // Reads requested against an empty queue.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_2000);
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

      // Reset mid-fetch with data buffered.
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      pulseReset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

      // Fetch PC wrap at the top of the address space; back-to-back redirects.
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_4444);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

      // Randomized traffic with varying dispatch pressure.
      for (int blk = 0; blk < 30; blk++) begin
         renPct = int'($urandom_range(10, 95));
         for (int i = 0; i < 100; i++) begin
            applyStimulus(($urandom_range(0, 99) < renPct),
                          ($urandom_range(0, 99) < 60),
                          ($urandom_range(0, 99) < 3),
                          $urandom);
         end
         if (blk == 15) pulseReset();
      end

      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge Clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch queue directly upstream of Dispatch_Decoder.
- Fetches 4-word (128-bit) lines from the instruction cache into a circular buffer.
- Presents one 32-bit instruction per read to dispatch, together with that instruction's PC+4.
- Dispatch, or the CDB on a branch mispredict, redirects the queue; a redirect flushes all buffered lines and restarts fetch at the target.

Parameters:
DEPTH, 4, number of 128-bit line entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
Clk  in  1  clock, rising edge
Resetb  in  1  asynchronous active-low reset
Cache_Rd_En  out  1  line fetch request to I-cache
Cache_Addr  out  32  line-aligned fetch address, bits [3:0] always 0
Cache_Dout  in  128  fetched line; word0 = [31:0]
Cache_Read_Hit  in  1  Cache_Dout valid for the current Cache_Addr
Ifetch_Instruction  out  32  head instruction, feeds Dispatch_Decoder Inst
Ifetch_PC_Plus4  out  32  PC of head instruction + 4
Ifetch_Empty  out  1  no valid instruction at head
Dispatch_Ren  in  1  consume head instruction this cycle
Redirect_Valid  in  1  flush and refetch (jump, taken branch, CDB flush)
Redirect_Addr  in  32  new PC, word-aligned; [1:0] ignored

Behaviour:
- State:
  - fetch PC register fpc[31:4]
  - per entry: line data plus line address [31:4]
  - wr_ptr and rd_ptr, each log2(DEPTH)+1 bits, with wrap bit
  - rd_word[1:0]
- full = pointers equal except the wrap bit. empty = pointers identical.
- Reset (async, Resetb=0):
  - fpc=RESET_PC[31:4]; pointers=0; rd_word=RESET_PC[3:2]
  - Cache_Rd_En=0; Ifetch_Empty=1; Ifetch_Instruction=0; Ifetch_PC_Plus4=0
- Fetch:
  - Cache_Rd_En = !full && !Redirect_Valid.
  - Cache_Addr = {fpc,4'b0}, held stable until a hit.
  - On a rising edge with Cache_Rd_En && Cache_Read_Hit: the line is written at wr_ptr with tag fpc, then wr_ptr++ and fpc++ (wraps mod 2^28).
  - Cache latency is arbitrary (>=0 cycles); no outstanding-request limit other than one at a time.
- Read:
  - Ifetch_Instruction = word rd_word of the head entry (combinational from storage); 0 when empty.
  - Ifetch_PC_Plus4 = {head_tag, rd_word, 2'b00} + 4, 32-bit wrap.
  - Ifetch_Empty = empty.
  - Dispatch_Ren && !empty: rd_word++. When rd_word==3, rd_word goes to 0 and rd_ptr++ (entry freed).
  - Dispatch_Ren while empty is ignored.
- Latency: a line written at edge N is visible at the outputs after edge N (no same-cycle bypass).
- Simultaneous read and write in one cycle are both performed. A full queue with its last word read frees the entry, but the next fetch is requested only from the following cycle, because full is evaluated from registered state.
- Redirect (Redirect_Valid=1, highest priority):
  - At the edge: wr_ptr=rd_ptr=0; fpc=Redirect_Addr[31:4]; rd_word=Redirect_Addr[3:2].
  - Any concurrent Dispatch_Ren or Cache_Read_Hit in that cycle is discarded.
  - Cache_Rd_En=0 in the redirect cycle; fetch at the target starts the next cycle.
  - Words preceding Redirect_Addr in the first line are skipped via the rd_word offset.
- Back-to-back redirects: the last one wins.

Optional Feature:
IFQ_STALL_CNT_EN
- Defined:
  - Adds output port Ifetch_Stall_Cnt [15:0].
  - Counter increments each cycle with Ifetch_Empty=1 && Redirect_Valid=0, and saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package ifq_pkg:
  - LINE_W=128, WORDS_PER_LINE=4, WORD_SEL_W=2, TAG_W=28
  - typedef ifq_entry_t {tag[27:0], data[127:0]}
  - RESET_PC default constant
- Sub-module ifq_line_ram:
  - DEPTH x 156-bit storage
  - single write port (clocked, wr_en/wr_addr)
  - asynchronous read port
  - no reset on the data array

Test Plan:
- Reset, then hold Cache_Read_Hit=1 returning words 0x20000000..0x20000003 at addr 0 -> Cache_Addr=0x0 then 0x10. Outputs Ifetch_Instruction=0x20000000 with PC_Plus4=0x4, then after three Dispatch_Ren: 0x20000003 with PC_Plus4=0x10.
- Never assert Dispatch_Ren; hits always 1 -> after 4 hits Cache_Rd_En=0, full. Then one line drained with 4 reads -> Cache_Rd_En returns to 1 on the cycle after the 4th read, with Cache_Addr=0x40.
- Redirect_Addr=0x0000_1238 while queue half full and a hit arrives the same cycle -> the hit is dropped and Ifetch_Empty=1 the next cycle. Next request has Cache_Addr=0x1230; first output has PC_Plus4=0x123C (word 2).
- Dispatch_Ren=1 with Ifetch_Empty=1 for 5 cycles -> pointers unchanged, no spurious read; with IFQ_STALL_CNT_EN, Ifetch_Stall_Cnt advances by 5.
- Resetb pulsed low mid-fetch with Cache_Rd_En=1 -> outputs go to reset values immediately (async); Cache_Addr=RESET_PC after release.
- Redirect to 0xFFFF_FFF0, then 2 hits -> second Cache_Addr=0x0000_0000 (fpc wraps). PC_Plus4 of word 3 of the first line = 0x0000_0000.
